// File: rtl/near_mem_bank.sv
// rtl/near_mem_bank.sv - word-addressed memory bank serving the engine bus and a host valid-ready port
// Clears itself after every reset; the engine bus always wins arbitration over the host.
module near_mem_bank #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_sel,
    input  logic                     mem_w,
    input  logic [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     host_we,
    input  logic [ADDR_WIDTH-1:0]    host_addr,
    input  logic [DATABUS_WIDTH-1:0] host_wdata,
    output logic                     host_rvalid,
    output logic [DATABUS_WIDTH-1:0] host_rdata,
    output logic                     init_done,
    output logic [CNT_WIDTH-1:0]     bus_wr_count,
    output logic                     bus_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
    logic                     init_done_q, init_done_d;
    logic                     host_rvalid_q, host_rvalid_d;
    logic [DATABUS_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic [CNT_WIDTH-1:0]     bus_wr_count_q, bus_wr_count_d;
    logic                     bus_err_q, bus_err_d;

    logic [DATABUS_WIDTH-1:0] mem_q [DEPTH];
    logic                     mem_we;
    logic [ADDR_WIDTH-1:0]    mem_waddr;
    logic [DATABUS_WIDTH-1:0] mem_wdata;

    logic eng_rd;
    logic eng_wr;
    logic host_xfer;

    assign eng_rd     = mem_sel & ~mem_w;
    assign eng_wr     = mem_sel & mem_w;
    assign host_ready = init_done_q & ~mem_sel;
    assign host_xfer  = host_valid & host_ready;

    // Reads during the clear sweep return zeros so stale contents never leak out.
    assign data_bus = eng_rd ? (init_done_q ? mem_q[address_bus] : '0) : 'z;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        init_done_d    = init_done_q;
        host_rvalid_d  = 1'b0;
        host_rdata_d   = host_rdata_q;
        bus_wr_count_d = bus_wr_count_q;
        bus_err_d      = bus_err_q;
        mem_we         = 1'b0;
        mem_waddr      = ptr_q;
        mem_wdata      = '0;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
                if (eng_wr) begin
                    bus_err_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (eng_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = address_bus;
                    mem_wdata = data_bus;
                    if (~&bus_wr_count_q) begin
                        bus_wr_count_d = bus_wr_count_q + 1'b1;
                    end
                end else if (host_xfer) begin
                    if (host_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = host_addr;
                        mem_wdata = host_wdata;
                    end else begin
                        host_rdata_d  = mem_q[host_addr];
                        host_rvalid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_INIT;
            ptr_q          <= '0;
            init_done_q    <= 1'b0;
            host_rvalid_q  <= 1'b0;
            host_rdata_q   <= '0;
            bus_wr_count_q <= '0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            init_done_q    <= init_done_d;
            host_rvalid_q  <= host_rvalid_d;
            host_rdata_q   <= host_rdata_d;
            bus_wr_count_q <= bus_wr_count_d;
            bus_err_q      <= bus_err_d;
        end
    end

    // The array itself has no reset; the sweep above zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign host_rvalid  = host_rvalid_q;
    assign host_rdata   = host_rdata_q;
    assign init_done    = init_done_q;
    assign bus_wr_count = bus_wr_count_q;
    assign bus_err      = bus_err_q;

endmodule

// File: doc/near_mem_bank.md
Name: near_mem_bank

Overview:
- Memory-side responder for the shared address_bus/data_bus protocol used by the layer engines (mem_sel, mem_w).
- Holds 2^ADDR_WIDTH words of DATABUS_WIDTH bits and answers engine reads combinationally in the same cycle.
- Captures engine writes on the clock edge.
- Provides a host/DMA valid-ready port to preload weights, biases and activations and to read back results.
- Clears itself to zero after every reset.

Parameters:
- ADDR_WIDTH, 8, address bits; depth DEPTH = 2^ADDR_WIDTH words.
- DATABUS_WIDTH, 32, word width.
- CNT_WIDTH, 16, width of the bus write counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_sel  input  1  engine bus select.
- mem_w  input  1  engine write strobe; 1 = write, 0 = read, qualified by mem_sel.
- address_bus  input  ADDR_WIDTH  engine word address; the bank never drives it.
- data_bus  inout  DATABUS_WIDTH  driven by the bank only on reads, high-Z otherwise.
- host_valid  input  1  host request valid.
- host_ready  output  1  host request accepted this cycle.
- host_we  input  1  host write (1) / read (0).
- host_addr  input  ADDR_WIDTH  host word address.
- host_wdata  input  DATABUS_WIDTH  host write data.
- host_rvalid  output  1  host read data valid, one-cycle pulse.
- host_rdata  output  DATABUS_WIDTH  host read data, registered.
- init_done  output  1  high once the clear sweep has finished.
- bus_wr_count  output  CNT_WIDTH  number of accepted engine writes, saturating.
- bus_err  output  1  sticky; set when an engine write arrives during INIT.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - host_rvalid=0, host_rdata=0, init_done=0, bus_wr_count=0, bus_err=0.
  - Init pointer = 0; FSM goes to INIT.
  - Array contents are not reset directly.
- FSM has two states, INIT and IDLE.
- INIT:
  - Each cycle writes mem[ptr] <= 0 and increments ptr.
  - On ptr == DEPTH-1 that word is cleared and the FSM moves to IDLE with init_done <= 1.
  - With the defaults, init_done rises on the 256th posedge after rst_n deasserts.
- IDLE: persistent until reset.
- Engine read (mem_sel=1, mem_w=0):
  - data_bus = mem[address_bus] combinationally, with zero-cycle latency. The engine presents an address and samples data_bus at the next posedge.
  - During INIT, data_bus is driven all zeros.
- Engine write (mem_sel=1, mem_w=1), at posedge:
  - In IDLE: mem[address_bus] <= data_bus; bus_wr_count increments and saturates at all-ones.
  - In INIT: the write is dropped, bus_err <= 1, and the count is unchanged.
- data_bus is high-Z whenever mem_sel=0 or mem_w=1.
- host_ready = init_done & ~mem_sel (combinational). The engine always has priority, so host and engine never access the array in the same cycle.
- Host transfer occurs when host_valid & host_ready at posedge:
  - Write: mem[host_addr] <= host_wdata.
  - Read: host_rdata <= mem[host_addr] and host_rvalid <= 1 for exactly one cycle.
- Back-to-back host reads are allowed every cycle; host_rvalid stays high while a transfer occurs each cycle.
- host_rvalid is 0 in any cycle following a non-transfer.
- host_rdata holds its last value when host_rvalid=0.
- Host request held while mem_sel=1: it is stalled and must stay stable. It completes in the first cycle with mem_sel=0.
- Read-after-write ordering: a read in a later cycle sees the written value. The array is written at posedge, so the combinational bus read in the next cycle returns the new data.
- Reset mid-operation:
  - All outputs return to reset values and the clear sweep re-runs.
  - A pending host request is discarded.
  - The host must re-issue the request after init_done.

Test Plan:
- Release rst_n and hold idle -> init_done rises exactly 256 posedges later; host read of 0x7F then returns host_rdata=0x00000000 with host_rvalid one cycle after acceptance.
- Host write 0x10=0xDEADBEEF, then mem_sel=1, mem_w=0, address_bus=0x10 -> data_bus=0xDEADBEEF in the same cycle; with mem_sel=0 -> data_bus is high-Z.
- Engine write mem_sel=1, mem_w=1, address_bus=0x20, data_bus=0x00000005 -> host read 0x20 returns 0x00000005; bus_wr_count=1.
- host_valid with write 0x30=0x12345678 held while mem_sel=1 for 3 cycles -> host_ready=0 for those 3 cycles; write accepted on the first mem_sel=0 cycle; readback 0x12345678.
- Engine write to 0x40=0xFFFFFFFF during INIT -> bus_err=1, bus_wr_count=0; after init_done, host read 0x40 returns 0.
- After the 0x10 write, pulse rst_n low mid-sequence -> all outputs zero and init re-runs; host read 0x10 after init_done returns 0.
